// File: rtl/board_cursor_ctrl.sv
// rtl/board_cursor_ctrl.sv - cursor/plot sequencer for an N x N game board
// Turns button edges into cell plot requests and writes placed disks to board RAM.
module board_cursor_ctrl #(
  parameter int BOARD_N    = 8,
  parameter int CELL_PITCH = 13,
  parameter int ORIGIN_X   = 9,
  parameter int ORIGIN_Y   = 9,
  parameter int X_W        = 8,
  parameter int Y_W        = 7,
  parameter int WRAP       = 0,
  parameter int AUTO_TURN  = 1,
  parameter int IDX_W      = $clog2(BOARD_N),
  parameter int ADDR_W     = $clog2(BOARD_N * BOARD_N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              move_up,
  input  logic              move_down,
  input  logic              move_left,
  input  logic              move_right,
  input  logic              place_req,
  input  logic              turn_side,
  input  logic              plot_ready,
  output logic              plot_valid,
  output logic [X_W-1:0]    x_plot,
  output logic [Y_W-1:0]    y_plot,
  output logic [1:0]        select,
  output logic [IDX_W-1:0]  cur_x,
  output logic [IDX_W-1:0]  cur_y,
  output logic              side,
  output logic              busy,
  output logic              cell_we,
  output logic [ADDR_W-1:0] cell_addr,
  output logic [1:0]        cell_data
);

  typedef enum logic [2:0] {S_INIT, S_BOX, S_IDLE, S_ERASE, S_DISK, S_WRITE} state_t;

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(BOARD_N - 1);

  state_t           state;
  logic [4:0]       btn_hist;
  logic [4:0]       edge_r;
  logic [4:0]       btns;
  logic             mv_ok;
  logic [IDX_W-1:0] nx;
  logic [IDX_W-1:0] ny;
  logic             handshake;
  logic             auto_flip;

  function automatic logic [X_W-1:0] px_x(input logic [IDX_W-1:0] i);
    return X_W'(ORIGIN_X + CELL_PITCH * int'(i));
  endfunction

  function automatic logic [Y_W-1:0] px_y(input logic [IDX_W-1:0] i);
    return Y_W'(ORIGIN_Y + CELL_PITCH * int'(i));
  endfunction

  assign btns      = {place_req, move_right, move_left, move_down, move_up};
  assign handshake = plot_valid && plot_ready;
  assign auto_flip = (AUTO_TURN != 0) && (state == S_WRITE);
  assign busy      = (state != S_IDLE);

  // Only the highest-priority edge is considered; if it points into a wall the move is dropped.
  always_comb begin
    nx    = cur_x;
    ny    = cur_y;
    mv_ok = 1'b0;
    if (edge_r[0]) begin
      if (cur_y != '0) begin ny = cur_y - 1'b1; mv_ok = 1'b1; end
      else if (WRAP != 0) begin ny = IDX_MAX; mv_ok = 1'b1; end
    end else if (edge_r[1]) begin
      if (cur_y != IDX_MAX) begin ny = cur_y + 1'b1; mv_ok = 1'b1; end
      else if (WRAP != 0) begin ny = '0; mv_ok = 1'b1; end
    end else if (edge_r[2]) begin
      if (cur_x != '0) begin nx = cur_x - 1'b1; mv_ok = 1'b1; end
      else if (WRAP != 0) begin nx = IDX_MAX; mv_ok = 1'b1; end
    end else if (edge_r[3]) begin
      if (cur_x != IDX_MAX) begin nx = cur_x + 1'b1; mv_ok = 1'b1; end
      else if (WRAP != 0) begin nx = '0; mv_ok = 1'b1; end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_INIT;
      btn_hist   <= btns;
      edge_r     <= '0;
      cur_x      <= '0;
      cur_y      <= '0;
      side       <= 1'b0;
      plot_valid <= 1'b0;
      x_plot     <= '0;
      y_plot     <= '0;
      select     <= 2'd0;
      cell_we    <= 1'b0;
      cell_addr  <= '0;
      cell_data  <= 2'd0;
    end else begin
      btn_hist <= btns;
      edge_r   <= btns & ~btn_hist;
      side     <= side ^ turn_side ^ auto_flip;
      cell_we  <= 1'b0;
      case (state)
        S_INIT: begin
          state      <= S_BOX;
          plot_valid <= 1'b1;
          x_plot     <= px_x(cur_x);
          y_plot     <= px_y(cur_y);
          select     <= 2'd1;
        end
        S_BOX: begin
          if (handshake) begin
            plot_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (edge_r[4]) begin
            state      <= S_DISK;
            plot_valid <= 1'b1;
            x_plot     <= px_x(cur_x);
            y_plot     <= px_y(cur_y);
            select     <= side ? 2'd2 : 2'd3;
          end else if (mv_ok) begin
            // The erase plot captures the old cell before the cursor moves.
            state      <= S_ERASE;
            plot_valid <= 1'b1;
            x_plot     <= px_x(cur_x);
            y_plot     <= px_y(cur_y);
            select     <= 2'd0;
            cur_x      <= nx;
            cur_y      <= ny;
          end
        end
        S_ERASE: begin
          if (handshake) begin
            state  <= S_BOX;
            x_plot <= px_x(cur_x);
            y_plot <= px_y(cur_y);
            select <= 2'd1;
          end
        end
        S_DISK: begin
          if (handshake) begin
            state      <= S_WRITE;
            plot_valid <= 1'b0;
            cell_we    <= 1'b1;
            cell_addr  <= ADDR_W'(int'(cur_y) * BOARD_N + int'(cur_x));
            cell_data  <= side ? 2'd2 : 2'd3;
          end
        end
        S_WRITE: begin
          state      <= S_BOX;
          plot_valid <= 1'b1;
          x_plot     <= px_x(cur_x);
          y_plot     <= px_y(cur_y);
          select     <= 2'd1;
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_board_cursor_ctrl.sv
// tb/tb_board_cursor_ctrl.sv - directed bench for board_cursor_ctrl (clamp and wrap instances)
module tb_board_cursor_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] btn;
  logic       turn_side;
  logic       plot_ready;
  logic       move_up, move_down, move_left, move_right, place_req;
  assign {place_req, move_right, move_left, move_down, move_up} = btn;

  localparam logic [4:0] B_UP = 5'b00001, B_DOWN = 5'b00010, B_LEFT = 5'b00100,
                         B_RIGHT = 5'b01000, B_PLACE = 5'b10000;

  logic       pv0, side0, busy0, we0;
  logic [7:0] xp0;
  logic [6:0] yp0;
  logic [1:0] sel0, data0;
  logic [2:0] cx0, cy0;
  logic [5:0] addr0;

  logic       pv1, side1, busy1, we1;
  logic [7:0] xp1;
  logic [6:0] yp1;
  logic [1:0] sel1, data1;
  logic [2:0] cx1, cy1;
  logic [5:0] addr1;

  board_cursor_ctrl #(.WRAP(0)) dut0 (
    .clk(clk), .reset(reset), .move_up(move_up), .move_down(move_down),
    .move_left(move_left), .move_right(move_right), .place_req(place_req),
    .turn_side(turn_side), .plot_ready(plot_ready), .plot_valid(pv0),
    .x_plot(xp0), .y_plot(yp0), .select(sel0), .cur_x(cx0), .cur_y(cy0),
    .side(side0), .busy(busy0), .cell_we(we0), .cell_addr(addr0), .cell_data(data0)
  );

  board_cursor_ctrl #(.WRAP(1)) dut1 (
    .clk(clk), .reset(reset), .move_up(move_up), .move_down(move_down),
    .move_left(move_left), .move_right(move_right), .place_req(place_req),
    .turn_side(turn_side), .plot_ready(plot_ready), .plot_valid(pv1),
    .x_plot(xp1), .y_plot(yp1), .select(sel1), .cur_x(cx1), .cur_y(cy1),
    .side(side1), .busy(busy1), .cell_we(we1), .cell_addr(addr1), .cell_data(data1)
  );

  int tests = 0;
  int fails = 0;
  int we_cnt = 0;

  always @(negedge clk) if (we0 === 1'b1) we_cnt++;

  function automatic logic [31:0] pk(input logic v, input logic [7:0] x,
                                     input logic [6:0] y, input logic [1:0] s);
    return {14'd0, v, x, y, s};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy0 || busy1) && n < 40) begin
      step();
      n++;
    end
    check("idle_timeout", 32'(busy0 | busy1), 32'd0);
  endtask

  task automatic press(input logic [4:0] b);
    btn = b;
    step();
    btn = '0;
    step();
    wait_idle();
  endtask

  initial begin
    reset = 1'b1; btn = '0; turn_side = 1'b0; plot_ready = 1'b1;
    step(); step();
    check("rst_plot", pk(pv0, xp0, yp0, sel0), pk(1'b0, 8'd0, 7'd0, 2'd0));
    check("rst_cur", 32'({cx0, cy0, side0}), 32'd0);
    check("rst_we", 32'({we0, addr0, data0}), 32'd0);
    reset = 1'b0;
    step();
    check("init_box", pk(pv0, xp0, yp0, sel0), pk(1'b1, 8'd9, 7'd9, 2'd1));
    step();
    check("init_idle", 32'({busy0, pv0, side0}), 32'd0);
    check("init_no_we", 32'(we_cnt), 32'd0);

    // move right from (0,0)
    btn = B_RIGHT; step();
    check("mv_latency", 32'(pv0), 32'd0);
    btn = '0; step();
    check("mv_erase", pk(pv0, xp0, yp0, sel0), pk(1'b1, 8'd9, 7'd9, 2'd0));
    check("mv_cur", 32'(cx0), 32'd1);
    step();
    check("mv_box", pk(pv0, xp0, yp0, sel0), pk(1'b1, 8'd22, 7'd9, 2'd1));
    step();
    check("mv_idle", 32'(busy0), 32'd0);

    // right wall: clamp vs wrap
    repeat (6) press(B_RIGHT);
    check("at_edge", 32'({cx0, cy0, cx1, cy1}), 32'({3'd7, 3'd0, 3'd7, 3'd0}));
    btn = B_RIGHT; step(); btn = '0; step();
    check("wall_ignored", 32'({pv0, busy0, cx0}), 32'({1'b0, 1'b0, 3'd7}));
    check("wrap_erase", pk(pv1, xp1, yp1, sel1), pk(1'b1, 8'd100, 7'd9, 2'd0));
    check("wrap_cur", 32'(cx1), 32'd0);
    step();
    check("wrap_box", pk(pv1, xp1, yp1, sel1), pk(1'b1, 8'd9, 7'd9, 2'd1));
    wait_idle();

    repeat (5) press(B_LEFT);
    repeat (3) press(B_DOWN);
    check("at_2_3", 32'({cx0, cy0}), 32'({3'd2, 3'd3}));

    // place with drawer stalled
    plot_ready = 1'b0;
    btn = B_PLACE; step(); btn = '0; step();
    check("disk", pk(pv0, xp0, yp0, sel0), pk(1'b1, 8'd35, 7'd48, 2'd3));
    for (int i = 0; i < 5; i++) begin
      step();
      check("disk_hold", pk(pv0, xp0, yp0, sel0), pk(1'b1, 8'd35, 7'd48, 2'd3));
    end
    plot_ready = 1'b1;
    step();
    check("write", 32'({we0, addr0, data0, pv0, side0}), 32'({1'b1, 6'd26, 2'd3, 1'b0, 1'b0}));
    step();
    check("write_box", pk(pv0, xp0, yp0, sel0), pk(1'b1, 8'd35, 7'd48, 2'd1));
    check("side_auto", 32'({side0, we0}), 32'({1'b1, 1'b0}));
    wait_idle();
    check("we_cnt1", 32'(we_cnt), 32'd1);

    // simultaneous up+left at (4,4)
    repeat (2) press(B_RIGHT);
    press(B_DOWN);
    btn = B_UP | B_LEFT; step(); btn = '0; step();
    check("ul_erase", pk(pv0, xp0, yp0, sel0), pk(1'b1, 8'd61, 7'd61, 2'd0));
    step();
    check("ul_box", pk(pv0, xp0, yp0, sel0), pk(1'b1, 8'd61, 7'd48, 2'd1));
    wait_idle();
    check("ul_cur", 32'({cx0, cy0}), 32'({3'd4, 3'd3}));

    // edge arriving while busy is dropped
    btn = B_RIGHT; step(); btn = '0; step();
    btn = B_DOWN; step(); btn = '0; step();
    repeat (3) step();
    wait_idle();
    check("busy_drop", 32'({cx0, cy0}), 32'({3'd5, 3'd3}));

    // reset during DISK aborts without a write
    btn = B_PLACE; step(); btn = '0; step();
    check("disk_side1", pk(pv0, xp0, yp0, sel0), pk(1'b1, 8'd74, 7'd48, 2'd2));
    reset = 1'b1; step(); reset = 1'b0;
    check("rst_abort", 32'({pv0, we0, cx0, cy0, side0}), 32'd0);
    step();
    check("rst_box", pk(pv0, xp0, yp0, sel0), pk(1'b1, 8'd9, 7'd9, 2'd1));
    wait_idle();
    check("we_cnt_abort", 32'(we_cnt), 32'd1);

    // turn_side coinciding with the auto toggle
    btn = B_PLACE; step(); btn = '0; step();
    check("disk_side0", pk(pv0, xp0, yp0, sel0), pk(1'b1, 8'd9, 7'd9, 2'd3));
    step();
    check("write2", 32'({we0, addr0, data0}), 32'({1'b1, 6'd0, 2'd3}));
    turn_side = 1'b1; step(); turn_side = 1'b0;
    check("turn_in_write", 32'(side0), 32'd0);
    wait_idle();
    turn_side = 1'b1; step(); turn_side = 1'b0;
    check("turn_idle", 32'(side0), 32'd1);
    check("we_cnt2", 32'(we_cnt), 32'd2);

    // button held through reset does not fire
    btn = B_DOWN; reset = 1'b1; step(); step(); reset = 1'b0;
    step();
    wait_idle();
    repeat (3) step();
    check("held_through_reset", 32'({cx0, cy0, busy0, pv0}), 32'd0);
    btn = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
